// File: rtl/sram22_pkg.sv
// ---------------------------------------------------------------------------
// sram22_pkg
// Shared types and helpers for the parametrised SRAM22 behavioural model.
//   sram22_state_t          : controller state (CLEAR while zeroing the array,
//                             RUN once normal accesses are allowed)
//   SRAM22_MAX_READ_LATENCY : largest supported read pipeline depth
//   SRAM22_MAX_LANE_BITS    : widest mask lane the parity helper accepts
//   sram22_lane_parity      : even parity of one (zero-extended) mask lane
// ---------------------------------------------------------------------------
package sram22_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } sram22_state_t;

   localparam int SRAM22_MAX_READ_LATENCY = 4;
   localparam int SRAM22_MAX_LANE_BITS    = 64;

   // Lanes narrower than SRAM22_MAX_LANE_BITS are zero-extended by the
   // caller; the padding does not change the XOR reduction.
   function automatic logic sram22_lane_parity(
      input logic [SRAM22_MAX_LANE_BITS-1:0] lane
   );
      return ^lane;
   endfunction

endpackage

// File: rtl/sram22_rd_pipe.sv
// ---------------------------------------------------------------------------
// sram22_rd_pipe
// Valid + data shift pipeline that delays a captured read word by DEPTH
// register stages. Each data stage only loads when a valid entry moves into
// it, so the last stage holds the most recent read word between reads.
// Asynchronous rst flushes every stage (valids and data to zero).
// Optional feature (macro SRAM22_PARITY_EN): the stored per-lane parity bits
// travel alongside the data.
// Ports:
//   clk, rst             : clock, asynchronous active-high flush
//   i_valid, i_data      : entry captured at the sampling edge
//   i_par                : stored parity bits of that entry (parity build)
//   o_valid, o_data      : last stage of the pipeline
//   o_par                : last-stage parity bits (parity build)
// ---------------------------------------------------------------------------
module sram22_rd_pipe #(
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 1
`ifdef SRAM22_PARITY_EN
   ,
   parameter int PAR_WIDTH  = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
`ifdef SRAM22_PARITY_EN
   input  logic [PAR_WIDTH-1:0]  i_par,
   output logic [PAR_WIDTH-1:0]  o_par,
`endif
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic [DEPTH-1:0]                 r_valid;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;

   // Shift the valid bits every cycle; a data stage is only overwritten
   // when a valid entry arrives so that the output stage keeps the last
   // completed read word while the pipeline is idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_data  <= '0;
      end else begin
         r_valid[0] <= i_valid;
         if (i_valid) begin
            r_data[0] <= i_data;
         end
         for (int s = 1; s < DEPTH; s++) begin
            r_valid[s] <= r_valid[s-1];
            if (r_valid[s-1]) begin
               r_data[s] <= r_data[s-1];
            end
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];

`ifdef SRAM22_PARITY_EN
   logic [DEPTH-1:0][PAR_WIDTH-1:0] r_par;

   // Parity bits follow exactly the same load rule as the data words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_par <= '0;
      end else begin
         if (i_valid) begin
            r_par[0] <= i_par;
         end
         for (int s = 1; s < DEPTH; s++) begin
            if (r_valid[s-1]) begin
               r_par[s] <= r_par[s-1];
            end
         end
      end
   end

   assign o_par = r_par[DEPTH-1];
`endif

endmodule

// File: rtl/sram22_param_sram.sv
// ---------------------------------------------------------------------------
// sram22_param_sram
// Parametrised behavioural stand-in for an SRAM22 single-port macro.
// After reset the array is zeroed one word per cycle (CLEAR); once the last
// word is written the macro reports ready and accepts one read or masked
// write per cycle (RUN). Reads are captured at the sampling edge and
// delivered READ_LATENCY-1 cycles later with a one-cycle dout_valid pulse.
// Optional feature (macro SRAM22_PARITY_EN): one even-parity bit per mask
// lane is stored with the data (XOR par_inv for error injection) and checked
// on read, reported on perr alongside dout_valid.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   ce, we       : chip enable, write (1) / read (0)
//   wmask        : per-lane write enable
//   addr, din    : word address, write data
//   dout         : read data, holds last read word between reads
//   dout_valid   : one pulse per completed read
//   ready        : high once the clear sequence is complete
//   par_inv      : per-lane stored-parity inversion (parity build only)
//   perr         : per-lane parity error on read (parity build only)
// ---------------------------------------------------------------------------
module sram22_param_sram
   import sram22_pkg::*;
#(
   parameter int DATA_WIDTH   = 128,
   parameter int ADDR_WIDTH   = 8,
   parameter int MASK_GRAN    = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              ce,
   input  logic                              we,
   input  logic [DATA_WIDTH/MASK_GRAN-1:0]   wmask,
   input  logic [ADDR_WIDTH-1:0]             addr,
   input  logic [DATA_WIDTH-1:0]             din,
   output logic [DATA_WIDTH-1:0]             dout,
   output logic                              dout_valid,
   output logic                              ready
`ifdef SRAM22_PARITY_EN
   ,
   input  logic [DATA_WIDTH/MASK_GRAN-1:0]   par_inv,
   output logic [DATA_WIDTH/MASK_GRAN-1:0]   perr
`endif
);

   localparam int                    RAM_DEPTH   = 2**ADDR_WIDTH;
   localparam int                    WMASK_WIDTH = DATA_WIDTH / MASK_GRAN;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

   // Reject configurations the read pipeline or lane slicing cannot support.
   if (READ_LATENCY < 1 || READ_LATENCY > SRAM22_MAX_READ_LATENCY) begin : g_badLatency
      $error("sram22_param_sram: READ_LATENCY must be in 1..%0d", SRAM22_MAX_READ_LATENCY);
   end
   if (DATA_WIDTH % MASK_GRAN != 0) begin : g_badGran
      $error("sram22_param_sram: DATA_WIDTH must be a multiple of MASK_GRAN");
   end
`ifdef SRAM22_PARITY_EN
   if (MASK_GRAN > SRAM22_MAX_LANE_BITS) begin : g_badLane
      $error("sram22_param_sram: MASK_GRAN exceeds parity helper width");
   end
`endif

   sram22_state_t         r_state;
   sram22_state_t         w_nextState;
   logic [ADDR_WIDTH-1:0] r_clrCnt;
   logic                  w_clrLast;
   logic                  w_wrFire;
   logic                  w_rdFire;
   logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

   // Controller state register; reset always restarts the clear sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= CLEAR;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Leave CLEAR on the cycle the final word is zeroed; RUN is sticky
   // until the next reset.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         CLEAR:   if (w_clrLast) w_nextState = RUN;
         RUN:     w_nextState = RUN;
         default: w_nextState = CLEAR;
      endcase
   end

   // The port is only honoured once the array has been fully zeroed.
   always_comb begin
      ready = (r_state == RUN);
   end

   assign w_clrLast = (r_state == CLEAR) && (r_clrCnt == LAST_ADDR);
   assign w_wrFire  = ce && we && ready;
   assign w_rdFire  = ce && !we && ready;

   // Clear address walks 0..RAM_DEPTH-1 while in CLEAR. It wraps back to 0
   // on the final word, which is harmless because the FSM leaves CLEAR on
   // that same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clrCnt <= '0;
      end else if (r_state == CLEAR) begin
         r_clrCnt <= r_clrCnt + 1'b1;
      end
   end

   // Storage array. Not reset: the clear sequence provides the defined
   // post-reset contents. Port writes update only the enabled lanes, and
   // the new contents are visible to a read sampled on the very next edge.
   always_ff @(posedge clk) begin
      if (r_state == CLEAR) begin
         r_mem[r_clrCnt] <= '0;
      end else if (w_wrFire) begin
         for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (wmask[i]) begin
               r_mem[addr][i*MASK_GRAN +: MASK_GRAN] <= din[i*MASK_GRAN +: MASK_GRAN];
            end
         end
      end
   end

`ifdef SRAM22_PARITY_EN
   logic [WMASK_WIDTH-1:0] r_par [RAM_DEPTH];
   logic [WMASK_WIDTH-1:0] w_wrPar;
   logic [WMASK_WIDTH-1:0] w_pipePar;

   // Parity to store for each incoming lane; par_inv deliberately corrupts
   // the stored bit so that a later read flags that lane.
   always_comb begin
      w_wrPar = '0;
      for (int i = 0; i < WMASK_WIDTH; i++) begin
         w_wrPar[i] = sram22_lane_parity(SRAM22_MAX_LANE_BITS'(din[i*MASK_GRAN +: MASK_GRAN]))
                      ^ par_inv[i];
      end
   end

   // Parity storage mirrors the data array lane for lane; cleared words
   // get parity 0, which matches all-zero data.
   always_ff @(posedge clk) begin
      if (r_state == CLEAR) begin
         r_par[r_clrCnt] <= '0;
      end else if (w_wrFire) begin
         for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (wmask[i]) begin
               r_par[addr][i] <= w_wrPar[i];
            end
         end
      end
   end

   sram22_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (READ_LATENCY),
      .PAR_WIDTH  (WMASK_WIDTH)
   ) u_rdPipe (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_rdFire),
      .i_data  (r_mem[addr]),
      .i_par   (r_par[addr]),
      .o_par   (w_pipePar),
      .o_valid (dout_valid),
      .o_data  (dout)
   );

   // Recompute parity on the emerging word; only meaningful on valid cycles.
   always_comb begin
      perr = '0;
      if (dout_valid) begin
         for (int i = 0; i < WMASK_WIDTH; i++) begin
            perr[i] = sram22_lane_parity(SRAM22_MAX_LANE_BITS'(dout[i*MASK_GRAN +: MASK_GRAN]))
                      ^ w_pipePar[i];
         end
      end
   end
`else
   sram22_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (READ_LATENCY)
   ) u_rdPipe (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_rdFire),
      .i_data  (r_mem[addr]),
      .o_valid (dout_valid),
      .o_data  (dout)
   );
`endif

endmodule

// File: tb/tb_sram22_param_sram.sv
// ---------------------------------------------------------------------------
// tb_sram22_param_sram
// Randomised scoreboard bench for sram22_param_sram (ADDR_WIDTH=4,
// READ_LATENCY=3). Issued reads push the reference word and the cycle it
// must appear; an independent monitor pops on dout_valid and compares.
// Optional feature (macro SRAM22_PARITY_EN) adds par_inv/perr coverage.
// ---------------------------------------------------------------------------
module tb_sram22_param_sram;

   localparam int DW    = 128;
   localparam int AW    = 4;
   localparam int MG    = 8;
   localparam int LAT   = 3;
   localparam int WM    = DW / MG;
   localparam int DEPTH = 1 << AW;

   logic          clk     = 1'b0;
   logic          rst     = 1'b0;
   logic          ce      = 1'b0;
   logic          we      = 1'b0;
   logic [WM-1:0] wmask   = '0;
   logic [AW-1:0] addr    = '0;
   logic [DW-1:0] din     = '0;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          ready;
`ifdef SRAM22_PARITY_EN
   logic [WM-1:0] par_inv = '0;
   logic [WM-1:0] perr;
`endif

   sram22_param_sram #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .MASK_GRAN    (MG),
      .READ_LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .we         (we),
      .wmask      (wmask),
      .addr       (addr),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .ready      (ready)
`ifdef SRAM22_PARITY_EN
      ,
      .par_inv    (par_inv),
      .perr       (perr)
`endif
   );

   always #5 clk = ~clk;

   // Edge counter used to timestamp when each read result is due.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      logic [WM-1:0] perr;
      int            due;
   } exp_t;

   exp_t          expQ[$];
   exp_t          monE;
   logic [DW-1:0] model    [DEPTH];
   logic [WM-1:0] parModel [DEPTH];
   logic [DW-1:0] expDout = '0;
   int            errors  = 0;
   int            checks  = 0;
   bit            monOn   = 1'b0;

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One bus cycle: drive, let the edge sample it, then update the model.
   // The model treats the memory as a plain array of words where each
   // enabled lane takes the new byte; reads expect the word LAT-1 edges on.
   task automatic applyStimulus(input logic c, input logic w, input logic [AW-1:0] a,
                                input logic [WM-1:0] m, input logic [DW-1:0] d,
                                input logic [WM-1:0] pinv);
      logic rdy;
      ce    = c;
      we    = w;
      addr  = a;
      wmask = m;
      din   = d;
`ifdef SRAM22_PARITY_EN
      par_inv = pinv;
`endif
      rdy = ready;
      @(posedge clk);
      #1;
      if (rdy && c) begin
         if (w) begin
            for (int i = 0; i < WM; i++) begin
               if (m[i]) begin
                  model[a][i*MG +: MG] = d[i*MG +: MG];
                  parModel[a][i]       = pinv[i];
               end
            end
         end else begin
            expQ.push_back('{data: model[a], perr: parModel[a], due: cyc + LAT - 1});
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
   endtask

   // Reset drops any in-flight reads and returns the array to all zeros.
   task automatic assertReset();
      rst = 1'b1;
      expQ.delete();
      expDout = '0;
      for (int i = 0; i < DEPTH; i++) begin
         model[i]    = '0;
         parModel[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset ready", ready, 0);
      checkOutput("reset dout_valid", dout_valid, 0);
      checkOutput("reset dout", dout, 0);
   endtask

   task automatic waitReady(input int expEdges);
      int n = 0;
      while (!ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      ce = 1'b0;
      we = 1'b0;
      checkOutput("edges to ready", n, expEdges);
   endtask

   function automatic logic [DW-1:0] rndWord();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Monitor: pops on every dout_valid; otherwise dout must hold.
   always @(negedge clk) begin
      if (monOn) begin
         if (dout_valid === 1'b1) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected dout_valid", dout_valid, 0);
            end else begin
               monE = expQ.pop_front();
               checkOutput("read data", dout, monE.data);
               checkOutput("read latency", cyc, monE.due);
`ifdef SRAM22_PARITY_EN
               checkOutput("perr", perr, monE.perr);
`endif
               expDout = monE.data;
            end
         end else begin
            checkOutput("dout hold", dout, expDout);
`ifdef SRAM22_PARITY_EN
            checkOutput("perr idle", perr, 0);
`endif
            if (expQ.size() > 0 && cyc > expQ[0].due) begin
               checkOutput("missing dout_valid", dout_valid, 1);
               void'(expQ.pop_front());
            end
         end
      end
   end

   initial begin
      logic [WM-1:0] pinv;
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      monOn = 1'b1;
      assertReset();

      // Reads issued during the clear are ignored; reset again at count 7.
      ce   = 1'b1;
      we   = 1'b0;
      addr = 4'h5;
      rst  = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      checkOutput("ready during clear", ready, 0);
      assertReset();

      // Writes during the clear must not reach the array.
      ce    = 1'b1;
      we    = 1'b1;
      addr  = 4'h3;
      wmask = '1;
      din   = rndWord();
      rst   = 1'b0;
      waitReady(DEPTH);

      // Every word reads back as zero after the clear.
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, AW'(i), '0, '0, '0);
      idle(LAT);

      // Full write then single-lane write of zero, then read back.
      applyStimulus(1'b1, 1'b1, 4'h5, '1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '0);
      applyStimulus(1'b1, 1'b1, 4'h5, 16'h0001, '0, '0);
      applyStimulus(1'b1, 1'b0, 4'h5, '0, '0, '0);
      idle(LAT);
      checkOutput("masked write word", dout, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3200);

      // Back-to-back reads of 1, 2, 3.
      for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b1, AW'(i), '1, rndWord(), '0);
      for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, AW'(i), '0, '0, '0);
      idle(LAT + 1);
      checkOutput("dout after burst", dout, model[3]);

`ifdef SRAM22_PARITY_EN
      applyStimulus(1'b1, 1'b1, 4'h9, 16'h0003, rndWord(), 16'h0002);
      applyStimulus(1'b1, 1'b0, 4'h9, '0, '0, '0);
      idle(LAT + 1);
`endif

      // Randomised traffic mixing reads, masked writes and idle cycles.
      for (int k = 0; k < 400; k++) begin
         pinv = '0;
`ifdef SRAM22_PARITY_EN
         if ($urandom_range(0, 3) == 0) pinv = WM'($urandom());
`endif
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                       AW'($urandom()),
                       ($urandom_range(0, 7) == 0) ? '0 : WM'($urandom()),
                       rndWord(), pinv);
      end
      idle(LAT + 1);

      // A read in flight when reset hits must never complete.
      applyStimulus(1'b1, 1'b1, 4'h7, '1, rndWord(), '0);
      applyStimulus(1'b1, 1'b0, 4'h7, '0, '0, '0);
      idle(1);
      assertReset();
      rst = 1'b0;
      waitReady(DEPTH);
      applyStimulus(1'b1, 1'b0, 4'h7, '0, '0, '0);
      for (int k = 0; k < 60; k++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                       AW'($urandom()), WM'($urandom()), rndWord(), '0);
      end
      idle(LAT + 2);
      checkOutput("pending reads drained", expQ.size(), 0);

      monOn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram22_param_sram.md
# sram22_param_sram

Parametrised behavioural model of an SRAM22 single-port macro: configurable depth, word width, write-mask granularity and read latency. Adds a post-reset clear sequencer, a `ready` indication and a read-data valid pipeline. Used as the simulation/synthesis stand-in for any generated sram22 instance in SoC integration, replacing per-size fixed models.

## Interface
Parameters:
- `DATA_WIDTH`, 128, word width in bits; must be a multiple of `MASK_GRAN`.
- `ADDR_WIDTH`, 8, address bits; depth `RAM_DEPTH = 2**ADDR_WIDTH`.
- `MASK_GRAN`, 8, bits per write-mask lane; `WMASK_WIDTH = DATA_WIDTH/MASK_GRAN`.
- `READ_LATENCY`, 1, cycles from the sampling edge of the read to `dout_valid`; legal range 1..4.

Ports:
- `clk`, in, 1, clock; all state updates on its rising edge.
- `rst`, in, 1, asynchronous, active-high reset.
- `ce`, in, 1, chip enable; the access is sampled when `ce && ready`.
- `we`, in, 1, 1 = write, 0 = read.
- `wmask`, in, `WMASK_WIDTH`, lane `i` writes `din[i*MASK_GRAN +: MASK_GRAN]`.
- `addr`, in, `ADDR_WIDTH`, word address.
- `din`, in, `DATA_WIDTH`, write data.
- `dout`, out, `DATA_WIDTH`, read data.
- `dout_valid`, out, 1, single-cycle pulse for each completed read.
- `ready`, out, 1, high once the clear sequence is done.
- `par_inv`, in, `WMASK_WIDTH`; present only with `SRAM22_PARITY_EN`.
- `perr`, out, `WMASK_WIDTH`; present only with `SRAM22_PARITY_EN`.

## Operation
- FSM states:
  - `CLEAR`: entered on `rst`. A clear counter starts at 0. Each cycle the counter's word is written to all-zero and the counter increments. When the counter reaches `RAM_DEPTH-1`, that word is written and the FSM moves to `RUN`.
  - `RUN`: normal accesses; the FSM stays here until `rst`.
- `ready` = (state == `RUN`).
- While `ready` is 0: `ce`, `we` and `addr` are ignored. No array write from the port, no read issued, no `dout_valid`.
- Write (`ce && we && ready`): only lanes with `wmask[i]=1` update. `wmask=0` writes nothing. No read is issued and `dout` is unchanged.
- Read (`ce && !we && ready`): `mem[addr]` is captured at that edge into a `READ_LATENCY`-deep valid/data pipeline. Back-to-back reads are accepted every cycle.
- `dout` loads only when a valid pipeline entry emerges. Otherwise it holds the last read data; `dout` is never X after reset.
- A write to address A followed by a read of A on the next cycle returns the new data. The array updates at the write edge.
- Reset values: `dout = 0`, `dout_valid = 0`, `ready = 0`, pipeline valids = 0, `perr = 0`, state = `CLEAR`, clear counter = 0.
- Reset asserted mid-clear or mid-read: the pipeline is flushed, in-flight reads are dropped (no `dout_valid`), and the clear sequence restarts from address 0.
- Address wrap: none needed; the clear counter is `ADDR_WIDTH` bits wide and terminates on the all-ones value.

## Timing
- Clear takes exactly `RAM_DEPTH` cycles after `rst` deasserts. `ready` rises on edge `RAM_DEPTH`, and the first access is sampled on the following edge.
- A read sampled at edge N produces `dout_valid = 1` and valid `dout` after edge `N+READ_LATENCY - 1`.
  - `READ_LATENCY = 1`: the data is visible in the cycle after the sampling edge.
- Write-to-array latency: 0 cycles beyond the sampling edge.
- Throughput: one access per cycle, read or write.

## Configuration
- Macro: `SRAM22_PARITY_EN`.
- Defined:
  - One even-parity bit is stored per mask lane and written together with that lane's data.
  - The stored bit is the computed parity XOR `par_inv[i]`; `par_inv` exists for error injection.
  - The clear sequence stores parity 0.
  - On read, parity is recomputed per lane. `perr[i]` is asserted with the same timing as `dout_valid`, only on valid cycles, and is 0 otherwise.
- Undefined: no parity storage, and the `par_inv`/`perr` ports are absent.

## Structure
- Package `sram22_pkg`:
  - state enum typedef `sram22_state_t` (`CLEAR`, `RUN`);
  - `SRAM22_MAX_READ_LATENCY = 4`;
  - parity helper function `sram22_lane_parity`.
- Sub-module `sram22_rd_pipe`: a parametrised valid+data shift pipeline of depth `READ_LATENCY` with asynchronous flush on `rst`. With `SRAM22_PARITY_EN` it also carries the parity bits.
- Elaboration check: error if `READ_LATENCY` is outside 1..4 or `DATA_WIDTH % MASK_GRAN != 0`.

## Test plan
- Reset then idle, `ADDR_WIDTH=4` → `ready` rises exactly 16 cycles after `rst` deasserts. Reads of addresses 0..15 all return 0 with one `dout_valid` each.
- Full write `addr=0x05`, `din=0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210`, `wmask=0xFFFF`; then write `din=0`, `wmask=0x0001`; then read 0x05 → `dout` = same value with byte 0 = 0x00.
- `READ_LATENCY=3`: reads of addresses 1, 2, 3 on consecutive cycles → three `dout_valid` pulses starting 2 cycles after the first sampling edge, in order. `dout` holds the value for address 3 afterwards.
- `ce=1`, `we=1` during `CLEAR` → no array change and no `dout_valid`. Assert `rst` mid-clear at count 7 → `ready` arrives a full `RAM_DEPTH` cycles after the release.
- Read issued and `rst` asserted one cycle later → no `dout_valid`; `dout = 0`.
- With `SRAM22_PARITY_EN`: write `wmask=0x0003`, `par_inv=0x0002`, then read → `perr = 0x0002` for exactly one cycle, coincident with `dout_valid`.
